// File: rtl/melody_seq.sv
// melody_seq: table-driven melody sequencer feeding the clkgen/sine/dac tone chain.
// Plays (pitch, duration) entries one-shot or looped with tick-exact note timing.
module melody_seq #(
    parameter int PITCH_BITWIDTH = 9,
    parameter int DUR_BITWIDTH   = 13,
    parameter int ADDR_BITWIDTH  = 5,
    parameter int TICK_BITWIDTH  = 11
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [TICK_BITWIDTH-1:0]  tick_maxval,
    input  logic                      wr_en,
    input  logic [ADDR_BITWIDTH-1:0]  wr_addr,
    input  logic [PITCH_BITWIDTH-1:0] wr_pitch,
    input  logic [DUR_BITWIDTH-1:0]   wr_duration,
    input  logic [ADDR_BITWIDTH:0]    length,
    input  logic                      loop_en,
    input  logic                      start,
    input  logic                      stop,
    output logic                      busy,
    output logic [PITCH_BITWIDTH-1:0] pitch,
    output logic                      gate,
    output logic                      note_start,
    output logic [ADDR_BITWIDTH-1:0]  note_index,
    output logic                      done
);

    localparam int DEPTH = 1 << ADDR_BITWIDTH;
    localparam int EW    = PITCH_BITWIDTH + DUR_BITWIDTH;
    localparam int LW    = ADDR_BITWIDTH + 1;

    typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

    state_t                      state;
    logic [EW-1:0]               mem [DEPTH];
    logic [EW-1:0]               rd_data;
    logic [ADDR_BITWIDTH-1:0]    rd_addr;
    logic [ADDR_BITWIDTH-1:0]    idx;
    logic [ADDR_BITWIDTH-1:0]    next_idx;
    logic [LW-1:0]               len_q;
    logic [LW-1:0]               len_clamp;
    logic                        loop_q;
    logic [TICK_BITWIDTH-1:0]    tick_ctr;
    logic [TICK_BITWIDTH-1:0]    tick_m;
    logic [DUR_BITWIDTH-1:0]     dur_ctr;
    logic [DUR_BITWIDTH-1:0]     dur_q;
    logic [PITCH_BITWIDTH-1:0]   rd_pitch;
    logic [DUR_BITWIDTH-1:0]     rd_dur;
    logic [DUR_BITWIDTH-1:0]     rd_dur_eff;
    logic                        tick;
    logic                        last;
    logic                        boundary;

    assign tick_m = (tick_maxval < TICK_BITWIDTH'(2))
                  ? TICK_BITWIDTH'(2) : tick_maxval;
    assign tick   = (tick_ctr == tick_m - TICK_BITWIDTH'(1));

    assign len_clamp = (length > LW'(DEPTH)) ? LW'(DEPTH) : length;
    assign last      = ({1'b0, idx} == len_q - LW'(1));
    assign next_idx  = last ? '0 : idx + ADDR_BITWIDTH'(1);
    assign boundary  = (state == PLAY) && tick
                     && (dur_ctr == dur_q - DUR_BITWIDTH'(1));

    // Entry 0 is read while idle; during a sequence the next note is prefetched.
    assign rd_addr    = (state == IDLE) ? '0 : next_idx;
    assign rd_pitch   = rd_data[EW-1:DUR_BITWIDTH];
    assign rd_dur     = rd_data[DUR_BITWIDTH-1:0];
    assign rd_dur_eff = (rd_dur == '0) ? DUR_BITWIDTH'(1) : rd_dur;

    // Note table: synchronous write, synchronous read-before-write, never cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {wr_pitch, wr_duration};
        end
        rd_data <= mem[rd_addr];
    end

    // Sequencer FSM with tick/duration counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            tick_ctr   <= '0;
            dur_ctr    <= '0;
            dur_q      <= '0;
            busy       <= 1'b0;
            pitch      <= '0;
            gate       <= 1'b0;
            note_start <= 1'b0;
            done       <= 1'b0;
        end else begin
            note_start <= 1'b0;
            done       <= 1'b0;
            if (stop) begin
                state    <= IDLE;
                idx      <= '0;
                tick_ctr <= '0;
                dur_ctr  <= '0;
                busy     <= 1'b0;
                pitch    <= '0;
                gate     <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && (length != '0)) begin
                            len_q  <= len_clamp;
                            loop_q <= loop_en;
                            idx    <= '0;
                            busy   <= 1'b1;
                            state  <= FETCH;
                        end
                    end
                    FETCH: begin
                        pitch      <= rd_pitch;
                        gate       <= (rd_pitch != '0);
                        dur_q      <= rd_dur_eff;
                        note_start <= 1'b1;
                        tick_ctr   <= '0;
                        dur_ctr    <= '0;
                        state      <= PLAY;
                    end
                    PLAY: begin
                        tick_ctr <= tick ? '0 : tick_ctr + TICK_BITWIDTH'(1);
                        if (boundary) begin
                            dur_ctr <= '0;
                            if (!last || loop_q) begin
                                idx        <= next_idx;
                                pitch      <= rd_pitch;
                                gate       <= (rd_pitch != '0);
                                dur_q      <= rd_dur_eff;
                                note_start <= 1'b1;
                            end else begin
                                state <= IDLE;
                                idx   <= '0;
                                busy  <= 1'b0;
                                pitch <= '0;
                                gate  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else if (tick) begin
                            dur_ctr <= dur_ctr + DUR_BITWIDTH'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign note_index = idx;

endmodule
